// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: opcodes, forwarding selects,
// FSM states and flag bit positions.
package ex_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_XOR = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_SLL = 4'd5,
    OP_SRA = 4'd6,
    OP_ROR = 4'd7,
    OP_MUL = 4'd8
  } aluop_e;

  localparam logic [1:0] FWD_SRC = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH steps,
// yielding the low WIDTH bits (identical for signed and unsigned operands).
module mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;

  // The first partial product is taken on the start edge, so the last one
  // lands WIDTH-1 cycles later and done is seen on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_a    <= i_a << 1;
      r_b    <= i_b >> 1;
      r_acc  <= i_b[0] ? i_a : '0;
      r_cnt  <= CW'(WIDTH - 1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        r_acc <= r_acc + (r_b[0] ? r_a : '0);
        r_a   <= r_a << 1;
        r_b   <= r_b >> 1;
        r_cnt <= r_cnt - CW'(1);
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_done    = r_busy && (r_cnt == '0);
  assign o_product = r_acc;

endmodule

// File: rtl/mod_ex_mc.sv
// Execute stage: forwarding muxes, single-cycle ALU with optional saturation,
// and an IDLE/MUL FSM that sequences the iterative multiplier.
module mod_ex_mc
  import ex_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluop,
  input  logic             alusrc,
  input  logic             memenable,
  input  logic [1:0]       branch,
  input  logic             pcread,
  input  logic             flag_en,
  input  logic [1:0]       fwd_sel1,
  input  logic [1:0]       fwd_sel2,
  input  logic [WIDTH-1:0] fwd_mem,
  input  logic [WIDTH-1:0] fwd_wb,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  output logic [WIDTH-1:0] aluout,
  output logic [2:0]       flag_out
);

  localparam int MSB = WIDTH - 1;
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] ROT_FULL = (SHW + 1)'(WIDTH);

  function automatic logic [WIDTH-1:0] fwdMux(input logic [1:0] sel,
                                               input logic [WIDTH-1:0] src,
                                               input logic [WIDTH-1:0] mem,
                                               input logic [WIDTH-1:0] wb);
    case (sel)
      FWD_SRC: return src;
      FWD_MEM: return mem;
      FWD_WB:  return wb;
      default: return wb;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] satVal(input logic neg);
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  state_e           r_state;
  state_e           w_nextState;
  logic [SHW-1:0]   r_count;
  logic [WIDTH-1:0] r_aluOut;
  logic             r_outValid;
  logic [2:0]       r_flags;
  logic             r_mulFlagOk;

  logic [WIDTH-1:0] w_sel1;
  logic [WIDTH-1:0] w_sel2;
  logic [WIDTH-1:0] w_opA;
  logic [WIDTH-1:0] w_opB;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [SHW-1:0]   w_shamt;
  logic [SHW:0]     w_rorAmt;
  logic [WIDTH-1:0] w_result;
  logic             w_ovf;
  logic             w_nvUpd;
  logic             w_zUpd;
  logic             w_flagOk;
  logic             w_isMul;
  logic             w_accept;
  logic             w_mulDone;
  logic             w_mulFinish;
  logic [WIDTH-1:0] w_mulProd;

  // Memory address generation uses a halfword-aligned base and a halfword
  // scaled immediate.
  assign w_sel1   = fwdMux(fwd_sel1, src1, fwd_mem, fwd_wb);
  assign w_sel2   = fwdMux(fwd_sel2, src2, fwd_mem, fwd_wb);
  assign w_opA    = memenable ? {w_sel1[MSB:1], 1'b0} : w_sel1;
  assign w_opB    = memenable ? (imm << 1) : (alusrc ? imm : w_sel2);
  assign w_sum    = w_opA + w_opB;
  assign w_diff   = w_opA - w_opB;
  assign w_shamt  = w_opB[SHW-1:0];
  assign w_rorAmt = ROT_FULL - {1'b0, w_shamt};

  assign w_flagOk = flag_en & ~branch[1] & ~branch[0] & ~pcread & ~memenable;
  assign w_isMul  = (aluop == OP_MUL);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    w_nvUpd  = 1'b0;
    w_zUpd   = 1'b0;
    case (aluop)
      OP_ADD: begin
        w_ovf    = (w_opA[MSB] == w_opB[MSB]) && (w_sum[MSB] != w_opA[MSB]);
        w_result = (SATURATE && w_ovf) ? satVal(w_opA[MSB]) : w_sum;
        w_nvUpd  = 1'b1;
        w_zUpd   = 1'b1;
      end
      OP_SUB: begin
        w_ovf    = (w_opA[MSB] != w_opB[MSB]) && (w_diff[MSB] != w_opA[MSB]);
        w_result = (SATURATE && w_ovf) ? satVal(w_opA[MSB]) : w_diff;
        w_nvUpd  = 1'b1;
        w_zUpd   = 1'b1;
      end
      OP_XOR: begin w_result = w_opA ^ w_opB; w_zUpd = 1'b1; end
      OP_AND: begin w_result = w_opA & w_opB; w_zUpd = 1'b1; end
      OP_OR:  begin w_result = w_opA | w_opB; w_zUpd = 1'b1; end
      OP_SLL: begin w_result = w_opA << w_shamt; w_zUpd = 1'b1; end
      OP_SRA: begin w_result = $signed(w_opA) >>> w_shamt; w_zUpd = 1'b1; end
      OP_ROR: begin
        w_result = (w_opA >> w_shamt) | (w_opA << w_rorAmt);
        w_zUpd   = 1'b1;
      end
      default: ;
    endcase
  end

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept && w_isMul),
    .i_a      (w_opA),
    .i_b      (w_opB),
    .o_done   (w_mulDone),
    .o_product(w_mulProd)
  );

  assign w_mulFinish = (r_state == ST_MUL) && (r_count == '0) && w_mulDone;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && w_isMul) w_nextState = ST_MUL;
      end
      ST_MUL: if (w_mulFinish) w_nextState = ST_IDLE;
    endcase
  end

  // Flag qualifiers are captured at MUL issue because the issue-side inputs
  // have moved on by the time the product is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_aluOut    <= '0;
      r_outValid  <= 1'b0;
      r_flags     <= 3'b000;
      r_mulFlagOk <= 1'b0;
    end else begin
      r_outValid <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_accept && w_isMul) begin
          r_count     <= SHW'(WIDTH - 1);
          r_mulFlagOk <= w_flagOk;
        end else if (w_accept) begin
          r_aluOut   <= w_result;
          r_outValid <= 1'b1;
          if (w_flagOk && w_nvUpd) begin
            r_flags[FLAG_N] <= w_result[MSB];
            r_flags[FLAG_V] <= w_ovf;
          end
          if (w_flagOk && w_zUpd) r_flags[FLAG_Z] <= (w_result == '0);
        end
      end else if (w_mulFinish) begin
        r_aluOut   <= w_mulProd;
        r_outValid <= 1'b1;
        if (r_mulFlagOk) r_flags[FLAG_Z] <= (w_mulProd == '0);
      end else if (r_count != '0) begin
        r_count <= r_count - SHW'(1);
      end
    end
  end

  assign out_valid = r_outValid;
  assign aluout    = r_aluOut;
  assign flag_out  = r_flags;

endmodule

// File: tb/tb_mod_ex_mc.sv
// Directed bench for mod_ex_mc: a saturating and a wrapping instance share
// every input so both arithmetic modes are exercised by the same vectors.
module tb_mod_ex_mc;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  aluop;
  logic        alusrc;
  logic        memenable;
  logic [1:0]  branch;
  logic        pcread;
  logic        flag_en;
  logic [1:0]  fwd_sel1;
  logic [1:0]  fwd_sel2;
  logic [15:0] fwd_mem;
  logic [15:0] fwd_wb;
  logic [15:0] src1;
  logic [15:0] src2;
  logic [15:0] imm;

  logic        rdy0, ov0, rdy1, ov1;
  logic [15:0] alu0, alu1;
  logic [2:0]  fl0, fl1;

  int checks = 0;
  int errors = 0;
  int lat;
  logic seen;

  always #5 clk = ~clk;

  mod_ex_mc #(.WIDTH(16), .SATURATE(1'b1)) dutSat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .aluop(aluop), .alusrc(alusrc), .memenable(memenable), .branch(branch),
    .pcread(pcread), .flag_en(flag_en), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .fwd_mem(fwd_mem), .fwd_wb(fwd_wb), .src1(src1), .src2(src2), .imm(imm),
    .out_valid(ov0), .aluout(alu0), .flag_out(fl0)
  );

  mod_ex_mc #(.WIDTH(16), .SATURATE(1'b0)) dutWrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .aluop(aluop), .alusrc(alusrc), .memenable(memenable), .branch(branch),
    .pcread(pcread), .flag_en(flag_en), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .fwd_mem(fwd_mem), .fwd_wb(fwd_wb), .src1(src1), .src2(src2), .imm(imm),
    .out_valid(ov1), .aluout(alu1), .flag_out(fl1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setOperands(input logic [3:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] im,
                             input logic src, input logic mem,
                             input logic [1:0] fs1, input logic [1:0] fs2,
                             input logic fen, input logic [1:0] br,
                             input logic pc);
    aluop = op; src1 = a; src2 = b; imm = im; alusrc = src; memenable = mem;
    fwd_sel1 = fs1; fwd_sel2 = fs2; flag_en = fen; branch = br; pcread = pc;
  endtask

  // One issue on the next rising edge; outputs are sampled 1 time unit later.
  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] im,
                               input logic src, input logic mem,
                               input logic [1:0] fs1, input logic [1:0] fs2,
                               input logic fen, input logic [1:0] br,
                               input logic pc);
    setOperands(op, a, b, im, src, mem, fs1, fs2, fen, br, pc);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; fwd_mem = 16'h0000; fwd_wb = 16'h0000;
    setOperands(OP_ADD, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
    tick();
    tick();
    checkOutput("rstReady", rdy0, 1);
    checkOutput("rstValid", ov0, 0);
    checkOutput("rstAlu", alu0, 16'h0000);
    checkOutput("rstFlags", fl0, 3'b000);
    rst = 1'b0;

    applyStimulus(OP_ADD, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0);
    checkOutput("addSatValid", ov0, 1);
    checkOutput("addSatAlu", alu0, 16'h7FFF);
    checkOutput("addSatFlags", fl0, 3'b010);
    checkOutput("addWrapAlu", alu1, 16'h8000);
    checkOutput("addWrapFlags", fl1, 3'b110);

    tick();
    checkOutput("pulseOneCycle", ov0, 0);
    checkOutput("aluHold", alu0, 16'h7FFF);

    fwd_mem = 16'h0010;
    applyStimulus(OP_XOR, 16'hFFFF, 16'h0010, 16'h0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 2'b00, 1'b0);
    checkOutput("xorFwdAlu", alu0, 16'h0000);
    checkOutput("xorFwdFlagsSat", fl0, 3'b011);
    checkOutput("xorFwdFlagsWrap", fl1, 3'b111);

    applyStimulus(OP_SUB, 16'h0005, 16'h0005, 16'h0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0);
    checkOutput("backToBackValid", ov0, 1);
    checkOutput("subZeroAlu", alu0, 16'h0000);
    checkOutput("subZeroFlags", fl0, 3'b001);

    applyStimulus(OP_ADD, 16'h1235, 16'h0, 16'h0003, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0);
    checkOutput("memAddrAlu", alu0, (16'h1235 & 16'hFFFE) + (16'h0003 << 1));
    checkOutput("memAddrFlags", fl0, 3'b001);

    fwd_wb = 16'h00F0;
    applyStimulus(OP_OR, 16'h0F0F, 16'hAAAA, 16'h0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 2'b00, 1'b0);
    checkOutput("orFwdWbAlu", alu0, 16'h0FFF);
    checkOutput("orFwdWbFlags", fl0, 3'b000);

    applyStimulus(OP_SLL, 16'h0001, 16'h0, 16'h0013, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
    checkOutput("sllAlu", alu0, 16'h0008);
    applyStimulus(OP_SRA, 16'h8000, 16'h0004, 16'h0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
    checkOutput("sraAlu", alu0, 16'hF800);
    applyStimulus(OP_ROR, 16'h1234, 16'h0, 16'h0004, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
    checkOutput("rorAlu", alu0, 16'h4123);
    checkOutput("shiftNoFlagEn", fl0, 3'b000);

    applyStimulus(OP_SUB, 16'h8000, 16'h0001, 16'h0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0);
    checkOutput("subSatAlu", alu0, 16'h8000);
    checkOutput("subSatFlags", fl0, 3'b110);
    checkOutput("subWrapAlu", alu1, 16'h7FFF);
    checkOutput("subWrapFlags", fl1, 3'b010);

    applyStimulus(OP_ADD, 16'h0001, 16'h0001, 16'h0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 1'b0);
    checkOutput("branchAlu", alu0, 16'h0002);
    checkOutput("branchHoldsFlags", fl0, 3'b110);
    applyStimulus(OP_ADD, 16'h0000, 16'h0000, 16'h0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b1);
    checkOutput("pcreadHoldsFlags", fl0, 3'b110);

    applyStimulus(4'd9, 16'h0005, 16'h0005, 16'h0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0);
    checkOutput("badOpValid", ov0, 1);
    checkOutput("badOpAlu", alu0, 16'h0000);
    checkOutput("badOpFlags", fl0, 3'b110);

    // Multiply with in_valid left high throughout: the extra issue must be dropped.
    setOperands(OP_MUL, 16'h0003, 16'hFFFC, 16'h0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0);
    in_valid = 1'b1;
    tick();
    checkOutput("mulAcceptReady", rdy0, 0);
    setOperands(OP_ADD, 16'h0001, 16'h0001, 16'h0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0);
    lat = 0;
    while (lat < 40) begin
      tick();
      lat++;
      if (ov0) break;
      checkOutput("mulBusyReady", rdy0, 0);
    end
    in_valid = 1'b0;
    checkOutput("mulLatency", lat, 16);
    checkOutput("mulAlu", alu0, 16'hFFF4);
    checkOutput("mulFlags", fl0, 3'b110);
    checkOutput("mulWrapAlu", alu1, 16'hFFF4);
    checkOutput("mulDoneReady", rdy0, 1);
    tick();
    checkOutput("mulDroppedIssue", ov0, 0);
    checkOutput("mulAluHold", alu0, 16'hFFF4);

    // Reset five cycles into a multiply, with an issue presented at the same time.
    setOperands(OP_MUL, 16'h0002, 16'h0003, 16'h0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    in_valid = 1'b1;
    setOperands(OP_ADD, 16'h0001, 16'h0001, 16'h0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0);
    tick();
    checkOutput("abortReady", rdy0, 1);
    checkOutput("abortValid", ov0, 0);
    checkOutput("abortAlu", alu0, 16'h0000);
    checkOutput("abortFlags", fl0, 3'b000);
    checkOutput("abortFlagsWrap", fl1, 3'b000);
    rst = 1'b0;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (ov0 || ov1) seen = 1'b1;
    end
    checkOutput("noLateResult", seen, 0);
    checkOutput("abortAluStays", alu0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
